// File: rtl/fft8_dit_sequencer.sv
// Load / compute / unload controller and in-place complex store for an 8-point radix-2 DIT FFT.
// Optional FFT8_INVERSE_EN adds an 'inverse' input that conjugates the twiddles for an unscaled IDFT.
module fft8_dit_sequencer #(
  parameter int BF_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_real,
  input  logic [31:0] in_imag,
`ifdef FFT8_INVERSE_EN
  input  logic        inverse,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_real,
  output logic [31:0] out_imag,
  output logic [2:0]  out_idx,
  output logic [31:0] bf_a_real,
  output logic [31:0] bf_a_imag,
  output logic [31:0] bf_b_real,
  output logic [31:0] bf_b_imag,
  output logic [31:0] bf_w_real,
  output logic [31:0] bf_w_imag,
  input  logic [31:0] bf_y0_real,
  input  logic [31:0] bf_y0_imag,
  input  logic [31:0] bf_y1_real,
  input  logic [31:0] bf_y1_imag,
  output logic        busy
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        bfi_q, bfi_d;
  logic [2:0]        wait_q, wait_d;
  logic [DATA_W-1:0] mem_re_q [8];
  logic [DATA_W-1:0] mem_re_d [8];
  logic [DATA_W-1:0] mem_im_q [8];
  logic [DATA_W-1:0] mem_im_d [8];
`ifdef FFT8_INVERSE_EN
  logic              inv_q, inv_d;
`endif

  logic [1:0]        stg;
  logic [2:0]        j3, span, top, bot, kk;
  logic [DATA_W-1:0] tw_re, tw_im;
  logic              bf_last;

  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  // Butterfly index {stage, j} maps to in-place addresses and a W8^k twiddle
  always_comb begin
    stg  = bfi_q[3:2];
    j3   = {1'b0, bfi_q[1:0]};
    span = 3'd1 << stg;
    top  = ((j3 >> stg) << (stg + 2'd1)) + (j3 & (span - 3'd1));
    bot  = top + span;
    kk   = (j3 & (span - 3'd1)) << (2'd2 - stg);
    case (kk)
      3'd1:    begin tw_re = 32'h3F3504F3; tw_im = 32'hBF3504F3; end
      3'd2:    begin tw_re = 32'h00000000; tw_im = 32'hBF800000; end
      3'd3:    begin tw_re = 32'hBF3504F3; tw_im = 32'hBF3504F3; end
      default: begin tw_re = 32'h3F800000; tw_im = 32'h00000000; end
    endcase
    bf_last = (wait_q == 3'(BF_WAIT));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bfi_d    = bfi_q;
    wait_d   = wait_q;
    mem_re_d = mem_re_q;
    mem_im_d = mem_im_q;
`ifdef FFT8_INVERSE_EN
    inv_d    = inv_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          mem_re_d[bitrev3(cnt_q)] = in_real;
          mem_im_d[bitrev3(cnt_q)] = in_imag;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = S_COMPUTE;
            bfi_d   = 4'd0;
            wait_d  = 3'd0;
`ifdef FFT8_INVERSE_EN
            inv_d   = inverse;
`endif
          end
        end
      end
      S_COMPUTE: begin
        if (bf_last) begin
          mem_re_d[top] = bf_y0_real;
          mem_im_d[top] = bf_y0_imag;
          mem_re_d[bot] = bf_y1_real;
          mem_im_d[bot] = bf_y1_imag;
          wait_d = 3'd0;
          bfi_d  = bfi_q + 4'd1;
          if (bfi_q == 4'd11) begin
            state_d = S_UNLOAD;
            cnt_d   = 3'd0;
          end
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_UNLOAD: begin
        if (out_ready) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Control is reset; the sample store is left free-running
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= 3'd0;
      bfi_q   <= 4'd0;
      wait_q  <= 3'd0;
`ifdef FFT8_INVERSE_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bfi_q   <= bfi_d;
      wait_q  <= wait_d;
`ifdef FFT8_INVERSE_EN
      inv_q   <= inv_d;
`endif
    end
    mem_re_q <= mem_re_d;
    mem_im_q <= mem_im_d;
  end

  always_comb begin
    in_ready  = (state_q == S_LOAD);
    busy      = (state_q == S_COMPUTE);
    out_valid = (state_q == S_UNLOAD);
    out_idx   = out_valid ? cnt_q : 3'd0;
    out_real  = mem_re_q[cnt_q];
    out_imag  = mem_im_q[cnt_q];
    bf_a_real = '0;
    bf_a_imag = '0;
    bf_b_real = '0;
    bf_b_imag = '0;
    bf_w_real = '0;
    bf_w_imag = '0;
    if (busy) begin
      bf_a_real = mem_re_q[top];
      bf_a_imag = mem_im_q[top];
      bf_b_real = mem_re_q[bot];
      bf_b_imag = mem_im_q[bot];
      bf_w_real = tw_re;
`ifdef FFT8_INVERSE_EN
      bf_w_imag = tw_im ^ {inv_q, 31'd0};
`else
      bf_w_imag = tw_im;
`endif
    end
  end

endmodule

// File: tb/tb_fft8_dit_sequencer.sv
// Bench for fft8_dit_sequencer: two instances (BF_WAIT 0 and 2) closed through a floating-point
// butterfly model; results are checked against a direct DFT and against exact test-plan values.
module tb_fft8_dit_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit cur_inv = 1'b0;

  logic        in_valid [2];
  logic        in_ready [2];
  logic [31:0] in_real [2];
  logic [31:0] in_imag [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_real [2];
  logic [31:0] out_imag [2];
  logic [2:0]  out_idx [2];
  logic [31:0] bf_a_real [2];
  logic [31:0] bf_a_imag [2];
  logic [31:0] bf_b_real [2];
  logic [31:0] bf_b_imag [2];
  logic [31:0] bf_w_real [2];
  logic [31:0] bf_w_imag [2];
  logic [31:0] bf_y0_real [2];
  logic [31:0] bf_y0_imag [2];
  logic [31:0] bf_y1_real [2];
  logic [31:0] bf_y1_imag [2];
  logic        busy [2];
`ifdef FFT8_INVERSE_EN
  logic        inverse [2];
`endif

  logic [31:0] in_r [8];
  logic [31:0] in_i [8];
  logic [31:0] got_r [8];
  logic [31:0] got_i [8];

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) m = 0.0;
    else m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** real'(e - 127));
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic   s;
    real    a;
    int     e;
    longint m;
    s = (x < 0.0);
    a = s ? -x : x;
    if (a < 1.0e-37) return {s, 31'd0};
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = longint'((a - 1.0) * 8388608.0);
    if (m >= 64'sd8388608) begin m = 0; e++; end
    return {s, 8'(e + 127), m[22:0]};
  endfunction

  function automatic real fabs(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  function automatic logic [63:0] bfly(input logic [31:0] ar, ai, br, bi, wr, wi, input logic sub);
    real tr, ti, yr, yi;
    tr = f2r(wr) * f2r(br) - f2r(wi) * f2r(bi);
    ti = f2r(wr) * f2r(bi) + f2r(wi) * f2r(br);
    yr = sub ? f2r(ar) - tr : f2r(ar) + tr;
    yi = sub ? f2r(ai) - ti : f2r(ai) + ti;
    return {r2f(yr), r2f(yi)};
  endfunction

  function automatic logic [63:0] twid(input int k);
    case (k)
      1:       return {32'h3F3504F3, 32'hBF3504F3};
      2:       return {32'h00000000, 32'hBF800000};
      3:       return {32'hBF3504F3, 32'hBF3504F3};
      default: return {32'h3F800000, 32'h00000000};
    endcase
  endfunction

  // Twiddle exponent expected for each of the 12 butterflies, in issue order
  function automatic int ktab(input int i);
    case (i)
      5, 7, 10: return 2;
      9:        return 1;
      11:       return 3;
      default:  return 0;
    endcase
  endfunction

  function automatic bit ulp_ok(input logic [31:0] g, input logic [31:0] w);
    int dlt;
    if ((g[30:0] == 31'd0) && (w[30:0] == 31'd0)) return 1'b1;
    if (g[31] != w[31]) return 1'b0;
    dlt = int'(g[30:0]) - int'(w[30:0]);
    return (dlt >= -1) && (dlt <= 1);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fft8_dit_sequencer #(.BF_WAIT(g * 2)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_real(in_real[g]), .in_imag(in_imag[g]),
`ifdef FFT8_INVERSE_EN
      .inverse(inverse[g]),
`endif
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_real(out_real[g]), .out_imag(out_imag[g]), .out_idx(out_idx[g]),
      .bf_a_real(bf_a_real[g]), .bf_a_imag(bf_a_imag[g]),
      .bf_b_real(bf_b_real[g]), .bf_b_imag(bf_b_imag[g]),
      .bf_w_real(bf_w_real[g]), .bf_w_imag(bf_w_imag[g]),
      .bf_y0_real(bf_y0_real[g]), .bf_y0_imag(bf_y0_imag[g]),
      .bf_y1_real(bf_y1_real[g]), .bf_y1_imag(bf_y1_imag[g]),
      .busy(busy[g])
    );
    assign {bf_y0_real[g], bf_y0_imag[g]} = bfly(bf_a_real[g], bf_a_imag[g], bf_b_real[g],
                                                 bf_b_imag[g], bf_w_real[g], bf_w_imag[g], 1'b0);
    assign {bf_y1_real[g], bf_y1_imag[g]} = bfly(bf_a_real[g], bf_a_imag[g], bf_b_real[g],
                                                 bf_b_imag[g], bf_w_real[g], bf_w_imag[g], 1'b1);
  end

  task automatic set_impulse(input int pos);
    for (int n = 0; n < 8; n++) begin
      in_r[n] = (n == pos) ? 32'h3F800000 : 32'h0;
      in_i[n] = 32'h0;
    end
  endtask

  task automatic set_random();
    for (int n = 0; n < 8; n++) begin
      in_r[n] = r2f((real'($urandom_range(0, 2000)) - 1000.0) / 1000.0);
      in_i[n] = r2f((real'($urandom_range(0, 2000)) - 1000.0) / 1000.0);
    end
  endtask

  task automatic load_frame(input int d, input bit inv, input bit gaps, output int acc_edge);
    cur_inv = inv;
    for (int n = 0; n < 8; n++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid[d] = 1'b0;
        @(posedge clk); #1;
      end
      n_vec++;
      if (in_ready[d] !== 1'b1) begin
        n_err++; $display("FAIL load_ready n=%0d: got %b want 1", n, in_ready[d]);
      end
      in_valid[d] = 1'b1;
      in_real[d]  = in_r[n];
      in_imag[d]  = in_i[n];
`ifdef FFT8_INVERSE_EN
      inverse[d]  = inv;
`endif
      @(posedge clk); #1;
    end
    acc_edge = cyc;
    in_valid[d] = 1'b0;
`ifdef FFT8_INVERSE_EN
    inverse[d] = ~inv;
`endif
  endtask

  // mode 0: always ready, 1: fixed 1,0,0,1,0,1 pattern, 2: random
  task automatic run_out(input int d, input int mode, input bit hold_valid, input int acc_edge);
    int w, c, got_n, bound;
    bit r, pstall;
    bit pat [6];
    logic [31:0] pr, pim;
    logic [127:0] pops;
    logic [63:0] ew;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    w = d * 2;
    c = 0;
    pops = '0;
    if (hold_valid) begin
      in_valid[d] = 1'b1; in_real[d] = $urandom; in_imag[d] = $urandom;
    end
    while ((out_valid[d] !== 1'b1) && (c < 200)) begin
      n_vec++;
      if ((busy[d] !== 1'b1) || (in_ready[d] !== 1'b0)) begin
        n_err++; $display("FAIL compute_ctl c=%0d: busy=%b in_ready=%b want 1/0", c, busy[d], in_ready[d]);
      end
      if (c < 12 * (w + 1)) begin
        ew = twid(ktab(c / (w + 1)));
`ifdef FFT8_INVERSE_EN
        ew[31] = ew[31] ^ cur_inv;
`endif
        n_vec++;
        if ({bf_w_real[d], bf_w_imag[d]} !== ew) begin
          n_err++; $display("FAIL twiddle c=%0d: got %h%h want %h", c, bf_w_real[d], bf_w_imag[d], ew);
        end
        if ((c % (w + 1)) != 0) begin
          n_vec++;
          if ({bf_a_real[d], bf_a_imag[d], bf_b_real[d], bf_b_imag[d]} !== pops) begin
            n_err++; $display("FAIL operand_hold c=%0d: got %h want %h", c,
                              {bf_a_real[d], bf_a_imag[d], bf_b_real[d], bf_b_imag[d]}, pops);
          end
        end
        pops = {bf_a_real[d], bf_a_imag[d], bf_b_real[d], bf_b_imag[d]};
      end
      c++;
      @(posedge clk); #1;
    end
    in_valid[d] = 1'b0;
    n_vec++;
    if (cyc - acc_edge != 12 * (w + 1)) begin
      n_err++; $display("FAIL latency: got %0d want %0d", cyc - acc_edge, 12 * (w + 1));
    end
    got_n = 0; pstall = 1'b0; bound = 0; pr = '0; pim = '0;
    while ((got_n < 8) && (bound < 100)) begin
      n_vec++;
      if ((out_valid[d] !== 1'b1) || (out_idx[d] !== got_n[2:0]) || (in_ready[d] !== 1'b0) || (busy[d] !== 1'b0)) begin
        n_err++; $display("FAIL unload_ctl: valid=%b idx=%0d in_ready=%b busy=%b want 1/%0d/0/0",
                          out_valid[d], out_idx[d], in_ready[d], busy[d], got_n);
      end
      if (pstall) begin
        n_vec++;
        if ({out_real[d], out_imag[d]} !== {pr, pim}) begin
          n_err++; $display("FAIL stall_stable: got %h/%h want %h/%h", out_real[d], out_imag[d], pr, pim);
        end
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = pat[bound % 6];
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready[d] = r;
      pr  = out_real[d];
      pim = out_imag[d];
      if (r) begin
        got_r[got_n] = out_real[d];
        got_i[got_n] = out_imag[d];
        got_n++;
      end
      pstall = !r;
      bound++;
      @(posedge clk); #1;
    end
    out_ready[d] = 1'b0;
    n_vec++;
    if ((got_n != 8) || (out_valid[d] !== 1'b0) || (in_ready[d] !== 1'b1)) begin
      n_err++; $display("FAIL frame_end: bins=%0d valid=%b in_ready=%b want 8/0/1", got_n, out_valid[d], in_ready[d]);
    end
  endtask

  task automatic check_dft(input string name);
    real xr [8];
    real xi [8];
    real er, ei, ang, tol, sgn;
    tol = 1.0;
    sgn = cur_inv ? 1.0 : -1.0;
    for (int n = 0; n < 8; n++) begin
      xr[n] = f2r(in_r[n]);
      xi[n] = f2r(in_i[n]);
      tol = tol + fabs(xr[n]) + fabs(xi[n]);
    end
    tol = tol * 1.0e-5;
    for (int k = 0; k < 8; k++) begin
      er = 0.0; ei = 0.0;
      for (int n = 0; n < 8; n++) begin
        ang = sgn * 2.0 * 3.14159265358979 * real'(n * k) / 8.0;
        er = er + xr[n] * $cos(ang) - xi[n] * $sin(ang);
        ei = ei + xr[n] * $sin(ang) + xi[n] * $cos(ang);
      end
      n_vec++;
      if ((fabs(f2r(got_r[k]) - er) > tol) || (fabs(f2r(got_i[k]) - ei) > tol)) begin
        n_err++; $display("FAIL %s X[%0d]: got %f,%f want %f,%f", name, k, f2r(got_r[k]), f2r(got_i[k]), er, ei);
      end
    end
  endtask

  task automatic check_idle(input int d, input string name);
    n_vec++;
    if ((in_ready[d] !== 1'b1) || (out_valid[d] !== 1'b0) || (busy[d] !== 1'b0) || (out_idx[d] !== 3'd0)) begin
      n_err++; $display("FAIL %s ctl: in_ready=%b out_valid=%b busy=%b idx=%0d want 1/0/0/0",
                        name, in_ready[d], out_valid[d], busy[d], out_idx[d]);
    end
    n_vec++;
    if ({bf_a_real[d], bf_a_imag[d], bf_b_real[d], bf_b_imag[d], bf_w_real[d], bf_w_imag[d]} !== 192'd0) begin
      n_err++; $display("FAIL %s bf_zero: a=%h b=%h w=%h want 0", name, bf_a_real[d], bf_b_real[d], bf_w_real[d]);
    end
  endtask

  task automatic impulse_frame(input int d, input string name);
    int acc;
    set_impulse(0);
    load_frame(d, 1'b0, 1'b0, acc);
    run_out(d, 0, 1'b0, acc);
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if ((got_r[k] !== 32'h3F800000) || (got_i[k][30:0] !== 31'd0)) begin
        n_err++; $display("FAIL %s X[%0d]: got %h/%h want 3F800000/+-0", name, k, got_r[k], got_i[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle(0, "post_reset");
  endtask

  task automatic test_impulse();
    impulse_frame(0, "impulse");
    check_dft("impulse_dft");
  endtask

  task automatic test_dc();
    int acc;
    for (int n = 0; n < 8; n++) begin in_r[n] = 32'h3F800000; in_i[n] = 32'h0; end
    load_frame(0, 1'b0, 1'b0, acc);
    run_out(0, 0, 1'b0, acc);
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if ((got_r[k] !== ((k == 0) ? 32'h41000000 : 32'h0) && !(k != 0 && got_r[k][30:0] == 31'd0))
          || (got_i[k][30:0] !== 31'd0)) begin
        n_err++; $display("FAIL dc X[%0d]: got %h/%h want %h/+-0", k, got_r[k], got_i[k],
                          (k == 0) ? 32'h41000000 : 32'h0);
      end
    end
  endtask

  task automatic test_shifted();
    int acc;
    set_impulse(1);
    load_frame(0, 1'b0, 1'b1, acc);
    run_out(0, 2, 1'b0, acc);
    n_vec++;
    if (!ulp_ok(got_r[1], 32'h3F3504F3) || !ulp_ok(got_i[1], 32'hBF3504F3)) begin
      n_err++; $display("FAIL shifted X[1]: got %h/%h want 3F3504F3/BF3504F3", got_r[1], got_i[1]);
    end
    n_vec++;
    if (!ulp_ok(got_r[2], 32'h0) || !ulp_ok(got_i[2], 32'hBF800000)) begin
      n_err++; $display("FAIL shifted X[2]: got %h/%h want 0/BF800000", got_r[2], got_i[2]);
    end
    n_vec++;
    if (!ulp_ok(got_r[4], 32'hBF800000) || !ulp_ok(got_i[4], 32'h0)) begin
      n_err++; $display("FAIL shifted X[4]: got %h/%h want BF800000/0", got_r[4], got_i[4]);
    end
    check_dft("shifted_dft");
  endtask

  task automatic test_backpressure();
    int acc;
    set_random();
    load_frame(0, 1'b0, 1'b1, acc);
    run_out(0, 1, 1'b1, acc);
    check_dft("backpressure_dft");
  endtask

  task automatic test_random();
    int acc;
    for (int f = 0; f < 4; f++) begin
      set_random();
      load_frame(0, 1'b0, 1'b1, acc);
      run_out(0, 2, f[0], acc);
      check_dft("random_dft");
    end
  endtask

  task automatic test_reset_mid_compute();
    int acc;
    set_random();
    load_frame(0, 1'b0, 1'b0, acc);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle(0, "rst_compute");
    impulse_frame(0, "after_rst_compute");
  endtask

  task automatic test_reset_mid_unload();
    int acc, c;
    set_random();
    load_frame(0, 1'b0, 1'b0, acc);
    c = 0;
    while ((out_valid[0] !== 1'b1) && (c < 100)) begin @(posedge clk); #1; c++; end
    n_vec++;
    if (out_valid[0] !== 1'b1) begin
      n_err++; $display("FAIL rst_unload_wait: out_valid got %b want 1", out_valid[0]);
    end
    out_ready[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    n_vec++;
    if (out_idx[0] !== 3'd4) begin
      n_err++; $display("FAIL rst_unload_idx: got %0d want 4", out_idx[0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle(0, "rst_unload");
    impulse_frame(0, "after_rst_unload");
  endtask

  task automatic test_bf_wait();
    int acc;
    impulse_frame(1, "wait2_impulse");
    set_random();
    load_frame(1, 1'b0, 1'b1, acc);
    run_out(1, 1, 1'b1, acc);
    check_dft("wait2_dft");
  endtask

`ifdef FFT8_INVERSE_EN
  task automatic test_inverse();
    int acc;
    set_impulse(1);
    load_frame(0, 1'b1, 1'b0, acc);
    run_out(0, 0, 1'b0, acc);
    n_vec++;
    if (!ulp_ok(got_r[1], 32'h3F3504F3) || !ulp_ok(got_i[1], 32'h3F3504F3)) begin
      n_err++; $display("FAIL inverse X[1]: got %h/%h want 3F3504F3/3F3504F3", got_r[1], got_i[1]);
    end
    check_dft("inverse_dft");
    set_random();
    load_frame(1, 1'b1, 1'b1, acc);
    run_out(1, 2, 1'b0, acc);
    check_dft("inverse_wait2_dft");
    cur_inv = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; in_real[d] = '0; in_imag[d] = '0;
`ifdef FFT8_INVERSE_EN
      inverse[d] = 1'b0;
`endif
    end
    test_reset();
    test_impulse();
    test_dc();
    test_shifted();
    test_backpressure();
    test_random();
    test_reset_mid_compute();
    test_reset_mid_unload();
    test_bf_wait();
`ifdef FFT8_INVERSE_EN
    test_inverse();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
